simon_decrypt: RTL and testbench
================================

// Module: simon_decrypt
// PURPOSE
//   Iterative SIMON block-cipher decryptor: the inverse of the SIMON encryptor, sharing its parameter set and key/word ordering.
//   Expands the key forward into a round-key RAM, then applies inverse rounds in descending key order, one round per clock.
//   Sits beside the encryptor in the crypto peripheral; the bus wrapper drives en/key/ciphertext and polls done.
// PARAMETERS
//   n  16  word size in bits (block = 2n, supported 16/24/32/48/64)
//   m  4   key words (key = n*m); legal (n,m) pairs as SIMON spec; illegal pair -> elaboration error
//   T  (localparam) rounds from (n,m): 32/36/42/44/52/54/68/69/72
// PORTS
//   clk         in   1      clock
//   rst         in   1      synchronous active-high reset
//   en          in   1      start pulse; samples ciphertext and key on this edge
//   ciphertext  in   2n     [2n-1:n]=x (left word), [n-1:0]=y (right word)
//   key         in   n*m    key[(i+1)*n-1 -: n] = k_i, k0 in LSBs
//   plaintext   out  2n     result, same x/y ordering, held until next en/rst
//   busy        out  1      high in EXPAND or DECRYPT
//   done        out  1      high in DONE
// BEHAVIOUR
//   Reset: state IDLE, counter 0, plaintext 0, busy 0, done 0, cache-valid 0. Synchronous to clk.
//   f(x) = (x<<<1 & x<<<8) ^ (x<<<2). Inverse round with k_i: x' = y; y' = x ^ f(y) ^ k_i.
//   Key step (m=4): t=k[i+3]>>>3 ^ k[i+1]; t^=t>>>1; k[i+4]=~k[i]^t^z_j[(i)%62]^3.
//     m=3: t=k[i+2]>>>3; m=2: t=k[i+1]>>>3; same t^=t>>>1 tail. z_j selected by (n,m).
//   FSM: IDLE -> EXPAND -> DECRYPT -> DONE; all arithmetic modulo n bits, rotates within n.
//     en=1 in ANY state (incl. mid-operation): load state reg<=ciphertext, ks[0..m-1]<=key words,
//       counter<=m, plaintext<=0, go EXPAND. en wins over every other transition.
//     EXPAND: write ks[counter]=step(ks[counter-m..counter-1]); counter++; after writing ks[T-1]
//       set counter<=T-1, go DECRYPT. Lasts T-m cycles.
//     DECRYPT: apply inverse round with ks[counter]; counter--; round using ks[0] registers
//       result into plaintext and goes DONE. Lasts T cycles.
//     DONE: hold plaintext, done=1 until en or rst. IDLE: hold, done=0.
//   Latency (no cache): done and plaintext valid 2T-m cycles after the en edge (n=16,m=4: 60).
//   en held high continuously restarts every cycle; no progress until deasserted.
//   rst mid-operation: immediate IDLE, outputs to reset values, round keys invalidated.
//   counter 8 bits; never wraps (max 71).
// CONFIGURATION
//   SIMON_DEC_KEYCACHE_EN defined: tag register stores last fully-expanded key plus valid bit.
//     On en with key == tag and valid=1: skip EXPAND, go directly DECRYPT with counter=T-1;
//     latency T cycles. valid set on EXPAND completion; cleared by rst or by en while in EXPAND.
//     Mismatching key: normal EXPAND path, tag overwritten on completion.
//   Not defined: no tag/compare logic; every en runs full EXPAND.
// STRUCTURE
//   simon_pkg: z0..z4 62-bit constants, rounds(n,m) function, z_index(n,m), state encodings,
//     rotl/rotr functions.
//   Sub-module simon_inv_round (combinational inverse round, x_s/k in, y out); key step kept inline.
//   Round-key store: reg array [T-1:0] of n bits, one write port, one read port.
// TESTING
//   n=16,m=4: key 64'h1918111009080100, ct 32'hc69be9bb -> pt 32'h65656877, done at +60 cycles.
//   n=32,m=4: key 128'h1b1a1918_13121110_0b0a0908_03020100, ct 64'h44c8fc20b9dfa07a
//     -> pt 64'h656b696c20646e75, done at +84 cycles.
//   Round-trip: random key/pt via simon encryptor, feed its ciphertext -> pt recovered, 200 vectors.
//   en re-pulsed at DECRYPT cycle 10 with new vector -> first result discarded, second correct,
//     done low until 60 cycles after second en; rst at EXPAND cycle 5 -> IDLE, plaintext 0, done 0.
//   SIMON_DEC_KEYCACHE_EN: same key twice -> second done at +32; different key -> +60;
//     en during EXPAND then same key -> full +60 (cache invalidated).

Source files
------------

// File: rtl/simon_decrypt_pkg.sv
// Shared definitions for the SIMON decryptor: round counts, z sequences,
// FSM state encoding and word rotate helpers.
package simon_decrypt_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXPAND  = 2'd1,
        S_DECRYPT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // z sequences written with z[0] as the leftmost (most significant) digit
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

    // Number of rounds for a legal (n,m) pair, 0 for an illegal pair
    function automatic int unsigned rounds(input int unsigned n, input int unsigned m);
        if (n == 16 && m == 4) return 32;
        if (n == 24 && m == 3) return 36;
        if (n == 24 && m == 4) return 36;
        if (n == 32 && m == 3) return 42;
        if (n == 32 && m == 4) return 44;
        if (n == 48 && m == 2) return 52;
        if (n == 48 && m == 3) return 54;
        if (n == 64 && m == 2) return 68;
        if (n == 64 && m == 3) return 69;
        if (n == 64 && m == 4) return 72;
        return 0;
    endfunction

    // Which z sequence the key schedule uses for a given (n,m)
    function automatic int unsigned z_index(input int unsigned n, input int unsigned m);
        if (n == 16) return 0;
        if (n == 24) return (m == 3) ? 0 : 1;
        if (n == 32) return (m == 3) ? 2 : 3;
        if (n == 48) return (m == 2) ? 2 : 3;
        if (n == 64) return (m == 2) ? 2 : ((m == 3) ? 3 : 4);
        return 0;
    endfunction

    function automatic logic [61:0] z_seq(input int unsigned j);
        case (j)
            0:       return Z0;
            1:       return Z1;
            2:       return Z2;
            3:       return Z3;
            default: return Z4;
        endcase
    endfunction

    // Rotate left by s within the low w bits of a 64-bit container
    function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned s, input int unsigned w);
        logic [63:0] mask;
        logic [63:0] xm;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        xm   = x & mask;
        return ((xm << s) | (xm >> (w - s))) & mask;
    endfunction

    // Rotate right by s within the low w bits of a 64-bit container
    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned s, input int unsigned w);
        return rotl(x, w - s, w);
    endfunction

endpackage

// File: rtl/simon_decrypt_if.sv
// Bus-side handshake of the SIMON decryptor: the wrapper is the master,
// the decryptor core is the slave.
interface simon_decrypt_if #(
    parameter int unsigned N = 16,
    parameter int unsigned M = 4
);
    logic             en;
    logic [2*N-1:0]   ciphertext;
    logic [N*M-1:0]   key;
    logic [2*N-1:0]   plaintext;
    logic             busy;
    logic             done;

    modport master (output en, ciphertext, key, input plaintext, busy, done);
    modport slave  (input en, ciphertext, key, output plaintext, busy, done);
endinterface

// File: rtl/simon_decrypt_inv_round.sv
// One combinational SIMON inverse round: (x, y) -> (y, x ^ f(y) ^ k).
module simon_decrypt_inv_round
    import simon_decrypt_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0] x_in,
    input  logic [N-1:0] y_in,
    input  logic [N-1:0] k,
    output logic [N-1:0] x_out,
    output logic [N-1:0] y_out
);
    logic [N-1:0] f_y;

    // f(y) = (y<<<1 & y<<<8) ^ (y<<<2), then undo one encryption round
    always_comb begin
        f_y   = (N'(rotl(64'(y_in), 1, N)) & N'(rotl(64'(y_in), 8, N))) ^ N'(rotl(64'(y_in), 2, N));
        x_out = y_in;
        y_out = x_in ^ f_y ^ k;
    end
endmodule

// File: rtl/simon_decrypt.sv
// Iterative SIMON decryptor: expands the key into a round-key store, then
// runs inverse rounds from the last round key down to k0, one per clock.
// Optional key cache enabled by defining SIMON_DEC_KEYCACHE_EN.
module simon_decrypt
    import simon_decrypt_pkg::*;
#(
    parameter int unsigned N = 16,
    parameter int unsigned M = 4
) (
    input  logic            clk,
    input  logic            rst,
    simon_decrypt_if.slave  bus
);
    localparam int unsigned T      = rounds(N, M);
    localparam int unsigned AW     = $clog2(T);
    localparam logic [7:0]  T_LAST = 8'(T - 1);
    localparam logic [7:0]  M_W    = 8'(M);
    localparam logic [61:0] Z_SEQ  = z_seq(z_index(N, M));

    if (T == 0) begin : g_bad_params
        $error("simon_decrypt: unsupported (N,M) parameter pair");
    end

    state_t         state;
    state_t         state_nx;
    logic [7:0]     cnt;
    logic [N-1:0]   ks  [T];
    logic [N-1:0]   win [M];
    logic [N-1:0]   xr;
    logic [N-1:0]   yr;
    logic [2*N-1:0] pt;
    logic [N-1:0]   x_nx;
    logic [N-1:0]   y_nx;
    logic [N-1:0]   rk;
    logic [N-1:0]   new_word;
    logic [N-1:0]   t;
    logic [7:0]     z_pos;
    logic [5:0]     z_sel;
    logic           cache_hit;

    assign rk            = ks[cnt[AW-1:0]];
    assign bus.plaintext = pt;

    simon_decrypt_inv_round #(.N(N)) u_round (
        .x_in  (xr),
        .y_in  (yr),
        .k     (rk),
        .x_out (x_nx),
        .y_out (y_nx)
    );

`ifdef SIMON_DEC_KEYCACHE_EN
    logic [N*M-1:0] tag;
    logic           tag_valid;

    // A stored key is only trusted once its expansion has completed
    assign cache_hit = tag_valid && (bus.key == tag) && (state != S_EXPAND);

    // Remember the last key sent through EXPAND and whether its schedule is complete
    always_ff @(posedge clk) begin
        if (rst) begin
            tag       <= '0;
            tag_valid <= 1'b0;
        end else if (bus.en) begin
            if (state == S_EXPAND) tag_valid <= 1'b0;
            if (!cache_hit)        tag       <= bus.key;
        end else if (state == S_EXPAND && cnt == T_LAST) begin
            tag_valid <= 1'b1;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // Key schedule step over the sliding window k[i..i+m-1] producing k[i+m]
    always_comb begin
        z_pos = cnt - M_W;
        if (z_pos >= 8'd62) z_pos = z_pos - 8'd62;
        z_sel = 6'(8'd61 - z_pos);
        t = N'(rotr(64'(win[M-1]), 3, N));
        if (M == 4) t = t ^ win[1];
        t = t ^ N'(rotr(64'(t), 1, N));
        new_word = ~win[0] ^ t ^ {{(N-1){1'b0}}, Z_SEQ[z_sel]} ^ N'(3);
    end

    // Next-state and status outputs; a start pulse overrides everything
    always_comb begin
        state_nx = state;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        if (bus.en) begin
            state_nx = cache_hit ? S_DECRYPT : S_EXPAND;
        end else begin
            case (state)
                S_EXPAND:  if (cnt == T_LAST) state_nx = S_DECRYPT;
                S_DECRYPT: if (cnt == 8'd0)   state_nx = S_DONE;
                default:   state_nx = state;
            endcase
        end
        case (state)
            S_EXPAND, S_DECRYPT: bus.busy = 1'b1;
            S_DONE:              bus.done = 1'b1;
            default:             ;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Round counter, cipher state and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 8'd0;
            xr  <= '0;
            yr  <= '0;
            pt  <= '0;
        end else if (bus.en) begin
            cnt <= cache_hit ? T_LAST : M_W;
            xr  <= bus.ciphertext[2*N-1:N];
            yr  <= bus.ciphertext[N-1:0];
            pt  <= '0;
        end else if (state == S_EXPAND) begin
            if (cnt != T_LAST) cnt <= cnt + 8'd1;
        end else if (state == S_DECRYPT) begin
            xr <= x_nx;
            yr <= y_nx;
            if (cnt == 8'd0) pt  <= {x_nx, y_nx};
            else             cnt <= cnt - 8'd1;
        end
    end

    // Round-key store and key-schedule window; contents are qualified by the FSM, not reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (bus.en) begin
                for (int j = 0; j < int'(M); j++) begin
                    ks[j]  <= bus.key[j*N +: N];
                    win[j] <= bus.key[j*N +: N];
                end
            end else if (state == S_EXPAND) begin
                ks[cnt[AW-1:0]] <= new_word;
                for (int j = 0; j < int'(M) - 1; j++) win[j] <= win[j+1];
                win[M-1] <= new_word;
            end
        end
    end
endmodule

// File: tb/tb_simon_decrypt.sv
// Self-checking bench for simon_decrypt: known-answer vectors, randomized
// round trips through a behavioural SIMON32/64 encryptor, restart, reset
// and key-cache latency scenarios.
module tb_simon_decrypt;

`ifdef SIMON_DEC_KEYCACHE_EN
    localparam int LAT_HIT = 32;
`else
    localparam int LAT_HIT = 60;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] mk [32];

    always #5 clk = ~clk;

    simon_decrypt_if #(.N(16), .M(4)) bus16 ();
    simon_decrypt_if #(.N(32), .M(4)) bus32 ();

    simon_decrypt #(.N(16), .M(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    simon_decrypt #(.N(32), .M(4)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    function automatic logic [15:0] rol16(input logic [15:0] x, input int s);
        return (x << s) | (x >> (16 - s));
    endfunction

    function automatic logic [15:0] ror16(input logic [15:0] x, input int s);
        return (x >> s) | (x << (16 - s));
    endfunction

    function automatic logic [15:0] f16(input logic [15:0] x);
        return (rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2);
    endfunction

    task automatic model_expand(input logic [63:0] key);
        string       z0;
        logic [15:0] tmp;
        z0 = "11111010001001010110000111001101111101000100101011000011100110";
        for (int i = 0; i < 4; i++) mk[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            tmp   = ror16(mk[i-1], 3) ^ mk[i-3];
            tmp   = tmp ^ ror16(tmp, 1);
            mk[i] = ~mk[i-4] ^ tmp ^ 16'(z0[i-4] == 8'h31) ^ 16'd3;
        end
    endtask

    function automatic logic [31:0] model_encrypt(input logic [31:0] p);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] tmp;
        x = p[31:16];
        y = p[15:0];
        for (int i = 0; i < 32; i++) begin
            tmp = x;
            x   = y ^ f16(x) ^ mk[i];
            y   = tmp;
        end
        return {x, y};
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] ct, input logic [63:0] key, input int hold);
        bus16.ciphertext = ct;
        bus16.key        = key;
        bus16.en         = 1'b1;
        repeat (hold) @(posedge clk);
        #1 bus16.en = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (bus16.done !== 1'b1 && cyc < limit) begin
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic run_vector(input string tag, input logic [63:0] key, input logic [31:0] p, input int exp_lat);
        int cyc;
        model_expand(key);
        apply_stimulus(model_encrypt(p), key, 1);
        wait_done(200, cyc);
        check_output($sformatf("%s latency", tag), 64'(cyc), 64'(exp_lat));
        check_output($sformatf("%s plaintext", tag), 64'(bus16.plaintext), 64'(p));
    endtask

    initial begin
        int          cyc;
        logic [63:0] k;
        logic [63:0] k2;
        logic [31:0] p;
        logic [31:0] p2;

        rst = 1'b1;
        bus16.en = 1'b0; bus16.ciphertext = '0; bus16.key = '0;
        bus32.en = 1'b0; bus32.ciphertext = '0; bus32.key = '0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset done",      64'(bus16.done),      64'd0);
        check_output("reset busy",      64'(bus16.busy),      64'd0);
        check_output("reset plaintext", 64'(bus16.plaintext), 64'd0);
        check_output("reset pt32",      bus32.plaintext,      64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        apply_stimulus(32'hc69be9bb, 64'h1918111009080100, 1);
        check_output("kat16 busy", 64'(bus16.busy), 64'd1);
        wait_done(200, cyc);
        check_output("kat16 latency",   64'(cyc),             64'd60);
        check_output("kat16 plaintext", 64'(bus16.plaintext), 64'h65656877);
        check_output("kat16 idle busy", 64'(bus16.busy),      64'd0);

        bus32.ciphertext = 64'h44c8fc20b9dfa07a;
        bus32.key        = 128'h1b1a1918_13121110_0b0a0908_03020100;
        bus32.en         = 1'b1;
        @(posedge clk);
        #1 bus32.en = 1'b0;
        cyc = 0;
        while (bus32.done !== 1'b1 && cyc < 300) begin
            @(posedge clk);
            #1 cyc++;
        end
        check_output("kat32 latency",   64'(cyc),        64'd84);
        check_output("kat32 plaintext", bus32.plaintext, 64'h656b696c20646e75);

        for (int v = 0; v < 200; v++) begin
            run_vector($sformatf("roundtrip%0d", v), {$urandom, $urandom}, $urandom, 60);
        end

        k = {$urandom, $urandom};
        p = $urandom;
        model_expand(k);
        apply_stimulus(model_encrypt(p), k, 5);
        wait_done(200, cyc);
        check_output("held en latency",   64'(cyc),             64'd60);
        check_output("held en plaintext", 64'(bus16.plaintext), 64'(p));

        k  = {$urandom, $urandom};
        p  = $urandom;
        k2 = {$urandom, $urandom};
        p2 = $urandom;
        model_expand(k);
        apply_stimulus(model_encrypt(p), k, 1);
        repeat (38) @(posedge clk);
        #1;
        check_output("restart done low", 64'(bus16.done), 64'd0);
        model_expand(k2);
        apply_stimulus(model_encrypt(p2), k2, 1);
        wait_done(200, cyc);
        check_output("restart latency",   64'(cyc),             64'd60);
        check_output("restart plaintext", 64'(bus16.plaintext), 64'(p2));

        k  = {$urandom, $urandom};
        run_vector("cache first",  k, $urandom, 60);
        run_vector("cache repeat", k, $urandom, LAT_HIT);
        run_vector("cache other",  {$urandom, $urandom}, $urandom, 60);

        k = {$urandom, $urandom};
        p = $urandom;
        model_expand(k);
        apply_stimulus(model_encrypt(p), k, 1);
        repeat (5) @(posedge clk);
        #1;
        run_vector("cache invalidated", k, p, 60);
        run_vector("cache revalidated", k, $urandom, LAT_HIT);

        model_expand(k);
        apply_stimulus(model_encrypt(p), k, 1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_output("midrst done",      64'(bus16.done),      64'd0);
        check_output("midrst busy",      64'(bus16.busy),      64'd0);
        check_output("midrst plaintext", 64'(bus16.plaintext), 64'd0);
        repeat (70) @(posedge clk);
        #1;
        check_output("midrst stays idle", 64'(bus16.done), 64'd0);
        run_vector("after rst", k, $urandom, 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
